// File: rtl/count_fifo_pkg.sv
// Shared defaults and width helpers for the count_fifo block.
package count_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // The level counter needs one bit more than a pointer, so it can represent DEPTH itself.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/count_fifo_mem.sv
// Storage array for count_fifo: one synchronous write port and one asynchronous read port.
module count_fifo_mem
  import count_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  // The contents are not reset; the controller's level and pointers decide what is valid.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/count_fifo.sv
// FIFO that queues samples from an upstream counter and keeps a sticky overflow flag.
// Defining COUNT_FIFO_CHANGE_EN makes it accept only samples that differ from the last accepted one.
module count_fifo
  import count_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            cin,
  input  logic                        cin_valid,
  output logic [WIDTH-1:0]            dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        full,
  output logic                        empty,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        overflow,
  input  logic                        clr_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] rd_data;
  logic             push_req, push, pop, drop;

  // Handshake: the head transfers on a rising edge where dout_valid and dout_ready are both 1;
  // cin_valid is a request that may be dropped (flagging overflow) when there is no room.
  assign empty      = (level_q == '0);
  assign full       = (level_q == LW'(DEPTH));
  assign dout_valid = ~empty;
  assign level      = level_q;
  assign overflow   = ovf_q;
  assign dout       = empty ? '0 : rd_data;

  assign pop  = dout_valid & dout_ready;

`ifdef COUNT_FIFO_CHANGE_EN
  logic [WIDTH-1:0] last_q;
  logic             seen_q;

  assign push_req = cin_valid & (~seen_q | (cin != last_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= '0;
      seen_q <= 1'b0;
    end else if (push) begin
      last_q <= cin;
      seen_q <= 1'b1;
    end
  end
`else
  assign push_req = cin_valid;
`endif

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = push_req & (~full | pop);
  assign drop = push_req & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  count_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (cin),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_count_fifo.sv
// Directed bench for count_fifo with hand-computed expectations and a drain scoreboard.
module tb_count_fifo;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] cin;
  logic         cin_valid;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         full;
  logic         empty;
  logic [3:0]   level;
  logic         overflow;
  logic         clr_ovf;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  count_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .cin        (cin),
    .cin_valid  (cin_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    cin       = v;
    cin_valid = 1'b1;
    step();
    cin_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    dout_ready = 1'b1;
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(dout_valid), 32'd1);
      check({tag, "_data"}, 32'(dout), 32'(e));
      step();
    end
    dout_ready = 1'b0;
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_dout0"}, 32'(dout), 32'd0);
  endtask

  initial begin
    reset      = 1'b0;
    cin        = '0;
    cin_valid  = 1'b0;
    dout_ready = 1'b0;
    clr_ovf    = 1'b0;
    #2;
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_dvalid", 32'(dout_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    step();
    reset = 1'b1;
    step();

    // fill 0x01..0x08 with no consumer
    cin = 8'h01;
    cin_valid = 1'b1;
    check("no_bypass", 32'(dout_valid), 32'd0);
    step();
    cin_valid = 1'b0;
    check("first_dout", 32'(dout), 32'h01);
    for (int i = 2; i <= 8; i++) push(W'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_level", 32'(level), 32'd8);
    check("fill_ovf", 32'(overflow), 32'd0);

    push(8'h09);
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_level", 32'(level), 32'd8);
    check("drop_head", 32'(dout), 32'h01);

    // clear coincides with another drop: set wins
    clr_ovf = 1'b1;
    push(8'h0A);
    check("clr_vs_drop", 32'(overflow), 32'd1);
    step();
    clr_ovf = 1'b0;
    check("clr_alone", 32'(overflow), 32'd0);
    check("clr_level", 32'(level), 32'd8);

    for (int i = 1; i <= 8; i++) exp_q.push_back(W'(i));
    drain("drain1");
    check("drain1_level", 32'(level), 32'd0);

    // full with simultaneous push and pop
    for (int i = 1; i <= 8; i++) push(W'(i));
    dout_ready = 1'b1;
    push(8'h20);
    dout_ready = 1'b0;
    check("pp_level", 32'(level), 32'd8);
    check("pp_full", 32'(full), 32'd1);
    check("pp_ovf", 32'(overflow), 32'd0);
    for (int i = 2; i <= 8; i++) exp_q.push_back(W'(i));
    exp_q.push_back(8'h20);
    drain("drain2");

    // reset mid-operation
    for (int i = 0; i < 5; i++) push(8'h41 + W'(i));
    check("pre_rst_level", 32'(level), 32'd5);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_dvalid", 32'(dout_valid), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    #1;
    reset = 1'b1;
    step();
    dout_ready = 1'b1;
    push(8'h33);
    dout_ready = 1'b0;
    check("post_rst_dout", 32'(dout), 32'h33);
    check("post_rst_level", 32'(level), 32'd1);
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    check("post_rst_empty", 32'(empty), 32'd1);

    // repeated samples
    push(8'h05);
    push(8'h05);
    push(8'h06);
    push(8'h06);
`ifdef COUNT_FIFO_CHANGE_EN
    check("chg_level", 32'(level), 32'd2);
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h06);
`else
    check("chg_level", 32'(level), 32'd4);
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h06);
    exp_q.push_back(8'h06);
`endif
    drain("drain3");
    check("final_ovf", 32'(overflow), 32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
